// File: rtl/virtual_uart_host_bridge_if.sv
// AXI-lite bus bundle between the virtual UART host bridge (master) and the
// virtual UART register slave, with master/slave modports.
interface virtual_uart_host_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/virtual_uart_host_bridge.sv
// Host-side AXI-lite sequencer for the virtual UART: drains TX on interrupt, injects RX bytes.
// Define VUART_BRIDGE_INIT_EN to build the INIT state that writes CONTROL=0x13 after reset.
module virtual_uart_host_bridge #(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          POLL_CYCLES = 16
) (
   input  logic                              clock_i,
   input  logic                              reset_ni,
   input  logic                              host_int_i,
   output logic [7:0]                        tx_data_o,
   output logic                              tx_valid_o,
   input  logic                              tx_ready_i,
   input  logic [7:0]                        rx_data_i,
   input  logic                              rx_valid_i,
   output logic                              rx_ready_o,
   output logic                              err_o,
   virtual_uart_host_bridge_if.master        m_axilite
);

   localparam int CNT_W = $clog2(POLL_CYCLES + 1);
   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);

`ifdef VUART_BRIDGE_INIT_EN
   typedef enum logic [3:0] {INIT, IDLE, TX_RD, TX_PUSH, ACK_WR, STS_RD, RX_WR, RX_WAIT} state_t;
   localparam state_t RESET_STATE = INIT;
`else
   typedef enum logic [2:0] {IDLE, TX_RD, TX_PUSH, ACK_WR, STS_RD, RX_WR, RX_WAIT} state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   function automatic logic isWrState(input state_t s);
      return (s == ACK_WR) || (s == RX_WR)
`ifdef VUART_BRIDGE_INIT_EN
             || (s == INIT)
`endif
             ;
   endfunction

   state_t           r_state;
   state_t           w_nextState;
   logic             r_reqIssued;
   logic             r_arvalid;
   logic             r_rready;
   logic             r_awvalid;
   logic             r_wvalid;
   logic             r_bready;
   logic [7:0]       r_txData;
   logic             r_rxReady;
   logic             r_err;
   logic [CNT_W-1:0] r_pollCnt;

   logic        w_rDone;
   logic        w_bDone;
   logic        w_rErr;
   logic        w_bErr;
   logic        w_rdState;
   logic        w_wrState;
   logic        w_issue;
   logic        w_errSet;
   logic        w_rxOkSet;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;

   assign w_rDone   = m_axilite.rvalid & r_rready;
   assign w_bDone   = m_axilite.bvalid & r_bready;
   assign w_rErr    = (m_axilite.rresp != 2'b00);
   assign w_bErr    = (m_axilite.bresp != 2'b00);
   assign w_rdState = (r_state == TX_RD) || (r_state == STS_RD);
   assign w_wrState = isWrState(r_state);
   // Requests go out on the second cycle of a bus state, exactly once per visit.
   assign w_issue   = (w_rdState || w_wrState) && !r_reqIssued;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_addr      = BASE_ADDR;
      w_wdata     = 32'h0;
      w_errSet    = 1'b0;
      w_rxOkSet   = 1'b0;
      case (r_state)
`ifdef VUART_BRIDGE_INIT_EN
         INIT: begin
            w_addr  = BASE_ADDR + 32'h0C;
            w_wdata = 32'h13;
            if (w_bDone) begin
               w_errSet    = w_bErr;
               w_nextState = IDLE;
            end
         end
`endif
         IDLE: begin
            if (host_int_i)      w_nextState = TX_RD;
            else if (rx_valid_i) w_nextState = STS_RD;
         end
         TX_RD: begin
            w_addr = BASE_ADDR + 32'h04;
            if (w_rDone) begin
               w_errSet    = w_rErr;
               w_nextState = w_rErr ? ACK_WR : TX_PUSH;
            end
         end
         TX_PUSH: begin
            if (tx_ready_i) w_nextState = ACK_WR;
         end
         ACK_WR: begin
            w_addr = BASE_ADDR + 32'h10;
            if (w_bDone) begin
               w_errSet    = w_bErr;
               w_nextState = IDLE;
            end
         end
         STS_RD: begin
            w_addr = BASE_ADDR + 32'h08;
            if (w_rDone) begin
               w_errSet = w_rErr;
               if (w_rErr)                    w_nextState = IDLE;
               else if (m_axilite.rdata[0])   w_nextState = RX_WAIT;
               else                           w_nextState = RX_WR;
            end
         end
         RX_WR: begin
            w_wdata = {24'b0, rx_data_i};
            if (w_bDone) begin
               w_errSet    = w_bErr;
               w_rxOkSet   = !w_bErr;
               w_nextState = IDLE;
            end
         end
         RX_WAIT: begin
            if (host_int_i || (r_pollCnt == POLL_LAST)) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_reqIssued <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_txData    <= 8'h0;
         r_rxReady   <= 1'b0;
         r_err       <= 1'b0;
         r_pollCnt   <= '0;
      end else begin
         r_reqIssued <= (w_nextState == r_state) ? (r_reqIssued | w_rdState | w_wrState) : 1'b0;

         if (w_issue && w_rdState)                    r_arvalid <= 1'b1;
         else if (r_arvalid && m_axilite.arready)     r_arvalid <= 1'b0;

         if (r_arvalid && m_axilite.arready)          r_rready <= 1'b1;
         else if (w_rDone)                            r_rready <= 1'b0;

         if (w_issue && w_wrState)                    r_awvalid <= 1'b1;
         else if (r_awvalid && m_axilite.awready)     r_awvalid <= 1'b0;

         if (w_issue && w_wrState)                    r_wvalid <= 1'b1;
         else if (r_wvalid && m_axilite.wready)       r_wvalid <= 1'b0;

         // bready opens on entry to a write state; the issue term covers INIT straight out of reset.
         if ((isWrState(w_nextState) && (w_nextState != r_state)) || (w_issue && w_wrState))
            r_bready <= 1'b1;
         else if (w_bDone)
            r_bready <= 1'b0;

         if ((r_state == TX_RD) && w_rDone && !w_rErr) r_txData <= m_axilite.rdata[7:0];

         r_err     <= w_errSet;
         r_rxReady <= w_rxOkSet;
         r_pollCnt <= ((r_state == RX_WAIT) && (w_nextState == RX_WAIT)) ? r_pollCnt + 1'b1 : '0;
      end
   end

   assign tx_data_o  = r_txData;
   assign tx_valid_o = (r_state == TX_PUSH);
   assign rx_ready_o = r_rxReady;
   assign err_o      = r_err;

   assign m_axilite.araddr  = w_addr;
   assign m_axilite.arprot  = 3'b000;
   assign m_axilite.arvalid = r_arvalid;
   assign m_axilite.rready  = r_rready;
   assign m_axilite.awaddr  = w_addr;
   assign m_axilite.awprot  = 3'b000;
   assign m_axilite.awvalid = r_awvalid;
   assign m_axilite.wdata   = w_wdata;
   assign m_axilite.wstrb   = 4'hF;
   assign m_axilite.wvalid  = r_wvalid;
   assign m_axilite.bready  = r_bready;

endmodule

// File: tb/tb_virtual_uart_host_bridge.sv
// Bench for virtual_uart_host_bridge: zero-wait virtual UART register slave model,
// transaction log and byte scoreboards for the TX drain and RX inject paths.
module tb_virtual_uart_host_bridge;

   localparam int          POLL = 16;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic       clock_i = 1'b0;
   logic       reset_ni = 1'b0;
   logic       host_int_i;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i = 1'b0;
   logic [7:0] rx_data_i = 8'h0;
   logic       rx_valid_i = 1'b0;
   logic       rx_ready_o;
   logic       err_o;

   virtual_uart_host_bridge_if axi ();

   virtual_uart_host_bridge #(.BASE_ADDR(BASE), .POLL_CYCLES(POLL)) dut (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .host_int_i (host_int_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_ready_o (rx_ready_o),
      .err_o      (err_o),
      .m_axilite  (axi)
   );

   always #5 clock_i = ~clock_i;

   // Slave model state; tasks request core-side actions through sequence counters.
   logic [7:0]  slvTx, slvRx;
   logic        slvRxFull, intPending;
   logic [31:0] slvCtrl;
   int          coreTxSeq = 0, coreRdSeq = 0, errReqSeq = 0;
   logic [7:0]  coreTxByte = 8'h0;
   int          seenTx = 0, seenRd = 0, errUsed = 0;
   logic [96:0] txnLog [0:1023];
   int          txnCount = 0;
   int          cycleNum = 0;
   int          rxReadyCnt = 0, errPulseCnt = 0;
   int          errors = 0, checks = 0;
   logic [7:0]  expTxQ[$];
   logic [7:0]  expRxQ[$];

   assign host_int_i  = intPending;
   assign axi.arready = reset_ni & ~axi.rvalid;
   assign axi.awready = reset_ni & axi.awvalid & axi.wvalid & ~axi.bvalid;
   assign axi.wready  = reset_ni & axi.awvalid & axi.wvalid & ~axi.bvalid;

   always @(posedge clock_i) cycleNum <= cycleNum + 1;

   always @(posedge clock_i) begin
      if (rx_ready_o) rxReadyCnt <= rxReadyCnt + 1;
      if (err_o) errPulseCnt <= errPulseCnt + 1;
   end

   always @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         axi.rvalid <= 1'b0; axi.rdata <= 32'h0; axi.rresp <= 2'b00;
         axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
         slvTx <= 8'h0; slvRx <= 8'h0; slvRxFull <= 1'b0; intPending <= 1'b0; slvCtrl <= 32'h0;
      end else begin
         if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
         if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
         if (axi.arvalid && axi.arready) begin
            axi.rvalid <= 1'b1;
            axi.rresp  <= 2'b00;
            case (axi.araddr - BASE)
               32'h0:   axi.rdata <= {24'b0, slvRx};
               32'h4:   axi.rdata <= {24'b0, slvTx};
               32'h8:   axi.rdata <= {31'b0, slvRxFull};
               default: axi.rdata <= 32'hDEAD_BEEF;
            endcase
            txnLog[txnCount] <= {1'b0, axi.araddr, 32'h0, 32'(cycleNum)};
            txnCount <= txnCount + 1;
         end
         if (axi.awvalid && axi.awready) begin
            axi.bvalid <= 1'b1;
            axi.bresp  <= 2'b00;
            txnLog[txnCount] <= {1'b1, axi.awaddr, axi.wdata, 32'(cycleNum)};
            txnCount <= txnCount + 1;
            if ((axi.awaddr == BASE) && (errReqSeq != errUsed)) begin
               axi.bresp <= 2'b10;
               errUsed   <= errUsed + 1;
            end else begin
               case (axi.awaddr - BASE)
                  32'h0:  begin slvRx <= axi.wdata[7:0]; slvRxFull <= 1'b1; end
                  32'hC:  slvCtrl <= axi.wdata;
                  32'h10: intPending <= 1'b0;
                  default: ;
               endcase
            end
         end
         if (coreTxSeq != seenTx) begin
            slvTx <= coreTxByte; intPending <= 1'b1; seenTx <= coreTxSeq;
         end
         if (coreRdSeq != seenRd) begin
            slvRxFull <= 1'b0; seenRd <= coreRdSeq;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock_i);
   endtask

   task automatic waitTxn(input int idx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (txnCount > idx) begin ok = 1'b1; break; end
         @(negedge clock_i);
      end
   endtask

   task automatic waitTxValid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock_i);
         if (tx_valid_o) begin ok = 1'b1; break; end
      end
   endtask

   // Drops rx_valid_i right after the pulse edge so IDLE does not see a stale request.
   task automatic waitRxReady(output bit ok, output int lat);
      ok = 1'b0; lat = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clock_i); #1; lat++;
         if (rx_ready_o) begin ok = 1'b1; break; end
      end
      rx_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      bit ok;
      int base;
      tick(3);
      checks++;
      if ({tx_valid_o, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready, rx_ready_o, err_o} !== 8'h0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b, expected 00000000",
                  {tx_valid_o, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready, rx_ready_o, err_o});
      end
      checks++;
      if (tx_data_o !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_txdata: got %h, expected 00", tx_data_o);
      end
      base = txnCount;
      reset_ni = 1'b1;
`ifdef VUART_BRIDGE_INIT_EN
      waitTxn(base, ok);
      tick(3);
      checks++;
      if (!ok || txnLog[base][96:32] !== {1'b1, BASE + 32'hC, 32'h13}) begin
         errors++; $display("[TB] FAIL init_ctrl: got %h ok=%0b, expected %h", txnLog[base][96:32], ok, {1'b1, BASE + 32'hC, 32'h13});
      end
`else
      tick(10);
      checks++;
      if (txnCount != base) begin
         errors++; $display("[TB] FAIL idle_quiet: got %0d txns, expected 0", txnCount - base);
      end
`endif
   endtask

   task automatic test_tx_drain(input logic [7:0] b, input int stall);
      bit ok;
      int base;
      logic [7:0] exp;
      base = txnCount;
      expTxQ.push_back(b);
      coreTxByte = b;
      coreTxSeq++;
      tx_ready_i = 1'b0;
      waitTxValid(ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL tx_valid_rise: got timeout, expected tx_valid_o=1"); end
      for (int i = 0; i < stall; i++) begin
         checks++;
         if (tx_valid_o !== 1'b1 || tx_data_o !== expTxQ[0]) begin
            errors++; $display("[TB] FAIL tx_hold: got valid=%b data=%h, expected valid=1 data=%h", tx_valid_o, tx_data_o, expTxQ[0]);
         end
         @(negedge clock_i);
      end
      tx_ready_i = 1'b1;
      exp = expTxQ.pop_front();
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== exp) begin
         errors++; $display("[TB] FAIL tx_byte: got valid=%b data=%h, expected valid=1 data=%h", tx_valid_o, tx_data_o, exp);
      end
      @(negedge clock_i);
      tx_ready_i = 1'b0;
      waitTxn(base + 1, ok);
      tick(2);
      checks++;
      if (!ok || host_int_i !== 1'b0) begin
         errors++; $display("[TB] FAIL tx_ack: got host_int=%b ok=%0b, expected host_int=0", host_int_i, ok);
      end
      checks++;
      if (txnLog[base][96:32] !== {1'b0, BASE + 32'h4, 32'h0}) begin
         errors++; $display("[TB] FAIL tx_rd_addr: got %h, expected %h", txnLog[base][96:32], {1'b0, BASE + 32'h4, 32'h0});
      end
      checks++;
      if (txnLog[base + 1][96:32] !== {1'b1, BASE + 32'h10, 32'h0}) begin
         errors++; $display("[TB] FAIL tx_ack_wr: got %h, expected %h", txnLog[base + 1][96:32], {1'b1, BASE + 32'h10, 32'h0});
      end
      tick(6);
      checks++;
      if (txnCount != base + 2 || tx_valid_o !== 1'b0) begin
         errors++; $display("[TB] FAIL tx_no_reservice: got %0d txns valid=%b, expected 2 txns valid=0", txnCount - base, tx_valid_o);
      end
   endtask

   task automatic test_rx_inject(input logic [7:0] b);
      bit ok;
      int base, lat;
      logic [7:0] exp;
      base = txnCount;
      expRxQ.push_back(b);
      rx_data_i = b;
      rx_valid_i = 1'b1;
      waitRxReady(ok, lat);
      checks++;
      if (!ok || lat < 6 || lat > 7) begin
         errors++; $display("[TB] FAIL rx_latency: got %0d cycles ok=%0b, expected 6..7", lat, ok);
      end
      @(posedge clock_i); #1;
      checks++;
      if (rx_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rx_pulse_width: got %b, expected 0", rx_ready_o); end
      exp = expRxQ.pop_front();
      checks++;
      if (txnLog[base][96:32] !== {1'b0, BASE + 32'h8, 32'h0}) begin
         errors++; $display("[TB] FAIL rx_sts_rd: got %h, expected %h", txnLog[base][96:32], {1'b0, BASE + 32'h8, 32'h0});
      end
      checks++;
      if (txnLog[base + 1][96:32] !== {1'b1, BASE, 24'h0, exp}) begin
         errors++; $display("[TB] FAIL rx_wr: got %h, expected %h", txnLog[base + 1][96:32], {1'b1, BASE, 24'h0, exp});
      end
      checks++;
      if (slvRxFull !== 1'b1 || slvRx !== exp) begin
         errors++; $display("[TB] FAIL rx_status: got full=%b rx=%h, expected full=1 rx=%h", slvRxFull, slvRx, exp);
      end
   endtask

   task automatic test_rx_poll(input logic [7:0] b);
      bit ok, ok2;
      int base, r0, lat, gap;
      logic [7:0] exp;
      base = txnCount;
      r0 = rxReadyCnt;
      expRxQ.push_back(b);
      rx_data_i = b;
      rx_valid_i = 1'b1;
      waitTxn(base + 1, ok);
      gap = int'(txnLog[base + 1][31:0] - txnLog[base][31:0]);
      checks++;
      if (!ok || txnLog[base][96:64] !== {1'b0, BASE + 32'h8} || txnLog[base + 1][96:64] !== {1'b0, BASE + 32'h8}) begin
         errors++; $display("[TB] FAIL poll_reads: got %h / %h ok=%0b, expected two reads of %h", txnLog[base][96:64], txnLog[base + 1][96:64], ok, BASE + 32'h8);
      end
      // AR-to-AR spacing: R beat, POLL wait cycles, one IDLE cycle, two STS_RD cycles.
      checks++;
      if (gap != POLL + 4) begin errors++; $display("[TB] FAIL poll_gap: got %0d, expected %0d", gap, POLL + 4); end
      checks++;
      if (rxReadyCnt != r0 || slvRxFull !== 1'b1) begin
         errors++; $display("[TB] FAIL poll_no_write: got pulses=%0d full=%b, expected 0 and 1", rxReadyCnt - r0, slvRxFull);
      end
      coreRdSeq++;
      waitRxReady(ok2, lat);
      exp = expRxQ.pop_front();
      checks++;
      if (!ok2 || txnLog[txnCount - 1][96:32] !== {1'b1, BASE, 24'h0, exp}) begin
         errors++; $display("[TB] FAIL poll_wr: got %h ok=%0b, expected %h", txnLog[txnCount - 1][96:32], ok2, {1'b1, BASE, 24'h0, exp});
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int base, lat;
      logic [7:0] expTx, expRx;
      logic [64:0] expSeq [4];
      coreRdSeq++;
      tick(3);
      base = txnCount;
      expTxQ.push_back(8'h7E);
      coreTxByte = 8'h7E;
      coreTxSeq++;
      @(posedge clock_i); #1;
      rx_data_i = 8'h11;
      rx_valid_i = 1'b1;
      expRxQ.push_back(8'h11);
      waitTxValid(ok);
      expTx = expTxQ.pop_front();
      checks++;
      if (!ok || tx_data_o !== expTx) begin
         errors++; $display("[TB] FAIL prio_tx: got data=%h ok=%0b, expected %h", tx_data_o, ok, expTx);
      end
      tx_ready_i = 1'b1;
      @(negedge clock_i);
      tx_ready_i = 1'b0;
      waitRxReady(ok, lat);
      expRx = expRxQ.pop_front();
      expSeq[0] = {1'b0, BASE + 32'h4, 32'h0};
      expSeq[1] = {1'b1, BASE + 32'h10, 32'h0};
      expSeq[2] = {1'b0, BASE + 32'h8, 32'h0};
      expSeq[3] = {1'b1, BASE, 24'h0, expRx};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (!ok || txnLog[base + i][96:32] !== expSeq[i]) begin
            errors++; $display("[TB] FAIL prio_order%0d: got %h ok=%0b, expected %h", i, txnLog[base + i][96:32], ok, expSeq[i]);
         end
      end
   endtask

   task automatic test_slverr(input logic [7:0] b);
      bit ok;
      int base, r0, e0, lat, rxWrites;
      logic [7:0] exp;
      coreRdSeq++;
      tick(3);
      base = txnCount;
      r0 = rxReadyCnt;
      e0 = errPulseCnt;
      errReqSeq++;
      expRxQ.push_back(b);
      rx_data_i = b;
      rx_valid_i = 1'b1;
      waitRxReady(ok, lat);
      tick(2);
      exp = expRxQ.pop_front();
      rxWrites = 0;
      for (int i = base; i < txnCount; i++)
         if (txnLog[i][96:64] == {1'b1, BASE}) rxWrites++;
      checks++;
      if (errPulseCnt - e0 != 1) begin errors++; $display("[TB] FAIL slverr_err: got %0d pulses, expected 1", errPulseCnt - e0); end
      checks++;
      if (!ok || rxReadyCnt - r0 != 1) begin errors++; $display("[TB] FAIL slverr_ready: got %0d pulses ok=%0b, expected 1", rxReadyCnt - r0, ok); end
      checks++;
      if (rxWrites != 2 || slvRx !== exp) begin
         errors++; $display("[TB] FAIL slverr_retry: got writes=%0d rx=%h, expected writes=2 rx=%h", rxWrites, slvRx, exp);
      end
   endtask

   task automatic test_reset_mid_push;
      bit ok;
      int base;
      logic [7:0] dropped;
      tx_ready_i = 1'b0;
      expTxQ.push_back(8'h99);
      coreTxByte = 8'h99;
      coreTxSeq++;
      waitTxValid(ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL rst_push_valid: got timeout, expected tx_valid_o=1"); end
      @(posedge clock_i); #2;
      reset_ni = 1'b0;
      #1;
      checks++;
      if ({tx_valid_o, axi.arvalid, axi.awvalid, axi.wvalid} !== 4'b0000) begin
         errors++; $display("[TB] FAIL rst_async: got %b, expected 0000", {tx_valid_o, axi.arvalid, axi.awvalid, axi.wvalid});
      end
      dropped = expTxQ.pop_back();
      tick(2);
      base = txnCount;
      reset_ni = 1'b1;
`ifdef VUART_BRIDGE_INIT_EN
      waitTxn(base, ok);
      checks++;
      if (!ok || txnLog[base][96:32] !== {1'b1, BASE + 32'hC, 32'h13}) begin
         errors++; $display("[TB] FAIL rst_init_first: got %h ok=%0b, expected %h", txnLog[base][96:32], ok, {1'b1, BASE + 32'hC, 32'h13});
      end
`else
      tick(10);
      checks++;
      if (txnCount != base || tx_valid_o !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_quiet: got %0d txns valid=%b (byte %h), expected 0 and 0", txnCount - base, tx_valid_o, dropped);
      end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_tx_drain(8'h41, 5);
      test_tx_drain(8'hA5, 0);
      test_rx_inject(8'h5A);
      test_rx_poll(8'h33);
      test_back_to_back();
      test_slverr(8'h66);
      test_reset_mid_push();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/virtual_uart_host_bridge.md
# virtual_uart_host_bridge

AXI-lite master that sequences the virtual UART's register datapath from the host side, replacing XDMA polling in simulation and standalone builds. It drains the TX register on each host interrupt, forwards the byte on a valid/ready output stream, acknowledges the interrupt, and injects bytes from an input stream into the RX register once the status register reports it free. It sits between the virtual UART's AXI-lite slave port, through the crossbar or directly, and a byte-stream consumer/producer such as a testbench console or physical UART shim.

## Interface
- BASE_ADDR, 0: byte address of virtual UART register 0; registers at +0x00 RX, +0x04 TX, +0x08 STATUS, +0x0C CONTROL, +0x10 HOST_INT_ACK
- POLL_CYCLES, 16: idle wait, in cycles, before re-reading STATUS when RX is still occupied; minimum 1
- clock_i  in  1  single clock
- reset_ni  in  1  reset, asynchronous, active-low
- host_int_i  in  1  virtual UART host interrupt, level (XDMA interrupt line)
- tx_data_o  out  8  byte drained from the TX register
- tx_valid_o  out  1  tx_data_o valid; held until tx_ready_i
- tx_ready_i  in  1  consumer accepts byte
- rx_data_i  in  8  byte to inject into the RX register
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  one-cycle pulse when the RX write completes with OKAY; the byte is consumed
- err_o  out  1  one-cycle pulse on any SLVERR/DECERR response
- m_axilite_*  AXI-lite master port using the codebase's standard AXI-lite master port set with prefix m; DATA_WIDTH 32

## Operation
- FSM states: INIT, IDLE, TX_RD, TX_PUSH, ACK_WR, STS_RD, RX_WR, RX_WAIT.
- IDLE priority: host_int_i=1 -> TX_RD; otherwise rx_valid_i=1 -> STS_RD; otherwise remain in IDLE.
- TX_RD: read BASE+0x04; capture rdata[7:0] into tx_data_o -> TX_PUSH. On error response: pulse err_o and go to ACK_WR without pushing a byte.
- TX_PUSH: tx_valid_o=1 until tx_ready_i; then -> ACK_WR.
- ACK_WR: write 0 to BASE+0x10, then -> IDLE after the B response.
- STS_RD: read BASE+0x08. If bit0 (RX valid)=0 -> RX_WR. Otherwise -> RX_WAIT.
- RX_WR: write {24'b0, rx_data_i} to BASE+0x00. On OKAY, pulse rx_ready_o; on error, pulse err_o and do not pulse rx_ready_o. Then -> IDLE.
- RX_WAIT: count POLL_CYCLES cycles, then -> IDLE. If host_int_i rises during the wait, leave RX_WAIT immediately for IDLE, so TX is serviced first.
- rx_data_i must be held stable while rx_valid_i=1 until rx_ready_o; the bridge does not register it.
- Only one AXI transaction is outstanding at a time.
- wstrb is always 4'hF; arprot and awprot are always 0.

## Timing
- Reset values: all valid outputs 0; bready 0; rready 0; tx_data_o 0; rx_ready_o 0; err_o 0; poll counter 0; state INIT (macro defined) or IDLE (macro undefined).
- Reset mid-transaction abandons the transaction immediately. The slave is reset by the same reset.
- Read channel: arvalid asserts the cycle after state entry and drops after the AR handshake. rready=1 from the AR handshake until the R handshake.
- Write channel: awvalid and wvalid assert together the cycle after state entry. Each drops after its own handshake; both stay high until that handshake, because the slave requires both valids to accept either. bready=1 from state entry until the B handshake.
- AXI request signals and address/data stay stable while the corresponding valid is high.
- host_int_i is sampled only in IDLE and RX_WAIT. An ACK completes before IDLE is re-entered, so a deasserted interrupt is never re-serviced.
- With a zero-wait slave: TX service completes in 7 cycles plus tx_ready_i wait, IDLE to IDLE. The rx_ready_o pulse arrives 6-7 cycles after rx_valid_i when RX is free.

## Configuration
- VUART_BRIDGE_INIT_EN defined: after reset the FSM starts in INIT and writes 0x13 to BASE+0x0C. This resets TX/RX and enables the interrupt. The FSM enters IDLE after the B response; an error response pulses err_o and still enters IDLE.
- VUART_BRIDGE_INIT_EN undefined: the INIT state is not built and the FSM starts in IDLE; software configures CONTROL.

## Test plan
- Core writes 0x41 to TX, raising host_int_i -> read of 0x04; tx_data_o=0x41 with tx_valid_o held while tx_ready_i=0 for 5 cycles; then a write to 0x10; host_int_i=0; FSM returns to IDLE.
- rx_valid_i=1 with rx_data_i=0x5A and RX empty -> read of 0x08, write of 0x5A to 0x00, one rx_ready_o pulse; the slave's STATUS bit0 reads 1.
- RX occupied (bit0=1) with POLL_CYCLES=16 -> exactly 16 wait cycles between STATUS reads. After core reads RX -> next poll writes the byte.
- host_int_i and rx_valid_i rise together -> the TX read is issued first; the RX injection follows after the ACK.
- Slave returns SLVERR on the RX write -> err_o pulses once, no rx_ready_o, byte retried on the next pass.
- Reset asserted during TX_PUSH -> tx_valid_o and all AXI valids go to 0 asynchronously. With VUART_BRIDGE_INIT_EN defined, the CONTROL write of 0x13 is the first transaction after release.
